// File: rtl/debounce_fsm_pkg.sv
// Shared state encoding for the switch debouncer and anything that decodes its state.
package debounce_fsm_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } state_t;

  // Debounced level is high in the stable-high state and while confirming a release.
  function automatic logic level_of(input state_t s);
    return (s == ONE) || (s == WAIT0);
  endfunction

endpackage

// File: rtl/debounce_fsm_if.sv
// Switch-side signal bundle: raw switch in, debounced level and rising tick out.
interface debounce_fsm_if;

  logic sw;
  logic db_level;
  logic db_tick;

  modport master (
    output sw,
    input  db_level,
    input  db_tick
  );

  modport slave (
    input  sw,
    output db_level,
    output db_tick
  );

endinterface

// File: rtl/debounce_fsm_bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous input bit; STAGES must be at least 2.
module bit_synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/debounce_fsm.sv
// Switch debouncer: synchronised input must hold for 2^CNT_W cycles before the level changes;
// a one-cycle Mealy tick marks each accepted rising transition.
module debounce_fsm
  import debounce_fsm_pkg::*;
#(
  parameter int unsigned CNT_W       = 21,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset,
  debounce_fsm_if.slave  bus
);

  logic             sw_s;
  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             cnt_zero;
  logic             tick;

  bit_synchronizer #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.sw),
    .q     (sw_s)
  );

  assign cnt_zero = (cnt_reg == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ZERO;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Tick depends only on registered state, counter and the synchronised input,
  // so it is glitch-free with respect to the raw switch.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    tick       = 1'b0;
    unique case (state_reg)
      ZERO: begin
        if (sw_s) begin
          state_next = WAIT1;
          cnt_next   = '1;
        end
      end
      WAIT1: begin
        if (!sw_s) begin
          state_next = ZERO;
        end else if (cnt_zero) begin
          state_next = ONE;
          tick       = 1'b1;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ONE: begin
        if (!sw_s) begin
          state_next = WAIT0;
          cnt_next   = '1;
        end
      end
      WAIT0: begin
        if (sw_s) begin
          state_next = ONE;
        end else if (cnt_zero) begin
          state_next = ZERO;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: begin
        state_next = ZERO;
      end
    endcase
  end

  assign bus.db_level = level_of(state_reg);
  assign bus.db_tick  = tick;

endmodule

// File: doc/debounce_fsm.md
Name: debounce_fsm

Overview:
Debounces a raw mechanical switch or pushbutton input into a clean, glitch-free level. It is the conditioning stage that feeds the rising-edge detector. The block synchronises the asynchronous input, then requires it to hold stable for 2^CNT_W clock cycles before changing the debounced level. It also emits a one-cycle Mealy pulse on each accepted rising transition, so simple consumers can skip a separate edge detector.

Parameters:
CNT_W, 21, width of the stability counter; stability window is 2^CNT_W cycles (~21 ms at 100 MHz).
SYNC_STAGES, 2, number of flip-flops in the input synchroniser chain (minimum 2).

Ports:
clk  input  1  system clock, all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
sw  input  1  raw, asynchronous, bouncing switch input.
db_level  output  1  debounced level, registered-state derived.
db_tick  output  1  one-cycle pulse on each accepted 0->1 transition, combinational Mealy output.

Behaviour:
- Clock and reset: clk is the clock; reset is asynchronous and active-high.
- Reset: synchroniser FFs=0, state=ZERO, cnt=0; therefore db_level=0 and db_tick=0. Reset asserted mid-wait aborts the wait immediately, with no pulse.
- Synchroniser: sw passes through a SYNC_STAGES FF chain to give sw_s. Only sw_s is used downstream.
- Counter cnt is CNT_W bits, unsigned. It is loaded with all-ones (MAX=2^CNT_W-1) and decrements by 1; it never wraps below 0.
- States (2-bit): ZERO, WAIT1, ONE, WAIT0.
- ZERO:
  - db_level=0.
  - sw_s=1 -> WAIT1, cnt<=MAX.
  - Otherwise stay.
- WAIT1:
  - db_level=0.
  - sw_s=0 -> ZERO (bounce rejected, no tick).
  - sw_s=1 and cnt!=0 -> cnt<=cnt-1.
  - sw_s=1 and cnt==0 -> ONE, and db_tick=1 this cycle.
- ONE:
  - db_level=1.
  - sw_s=0 -> WAIT0, cnt<=MAX.
  - Otherwise stay.
- WAIT0:
  - db_level=1.
  - sw_s=1 -> ONE (bounce rejected).
  - sw_s=0 and cnt!=0 -> decrement.
  - sw_s=0 and cnt==0 -> ZERO. No tick is produced on the falling transition.
- Illegal or default state -> ZERO.
- db_level is decoded from state_reg only: high in ONE and WAIT0. No combinational path from sw.
- db_tick is high only when state_reg=WAIT1, cnt==0 and sw_s=1. It is never high for more than one consecutive cycle.
- Latency, with sw first sampled high at edge s and held:
  - sw_s is high after edge s+SYNC_STAGES-1.
  - db_tick is high in the cycle after edge s+SYNC_STAGES+2^CNT_W-1.
  - db_level rises after edge s+SYNC_STAGES+2^CNT_W.
  - Falling latency is identical, without a tick.
- Bounce rule: any sw_s reversal inside a WAIT state returns to the previous stable state. The full window restarts on the next change.
- Continuous toggling faster than the window leaves db_level unchanged indefinitely.

Decomposition:
- Shared package: state encoding localparams ZERO=2'b00, WAIT1=2'b01, ONE=2'b10, WAIT0=2'b11, plus the state width.
- One natural sub-module: bit_synchronizer (parameter STAGES, ports clk, reset, d, q), reused by other async input paths.
- FSM and counter stay in debounce_fsm.

Test Plan (CNT_W=4, SYNC_STAGES=2, so window=16):
- Reset: assert reset mid-wait with sw=1 -> db_level=0 and db_tick=0 immediately. After release with sw=1 held, db_level rises 18 edges after the first sampling edge.
- Clean press: sw 0->1 held, first sampled at edge 10 -> db_tick high only in the cycle after edge 27; db_level=1 from edge 28 on.
- Bounce on press: sw high 5 cycles, low 2, high held -> no tick during bounce; tick and db_level timing restart from the last rising sample (+17/+18 edges).
- Clean release: from ONE, sw 1->0 held, first sampled at edge 50 -> db_level=0 from edge 68; db_tick stays 0 throughout.
- Release bounce: sw low 10 cycles then high 3 then low held -> db_level stays 1 until 18 edges after the final falling sample.
- Rapid toggle: sw toggles every 4 cycles for 200 cycles -> db_level constant and db_tick never asserted.
